// File: rtl/cmd_ext_trigger.sv
// rtl/cmd_ext_trigger.sv - external trigger to one-cycle command start flag; optional glitch filter via CMD_TRIG_GLITCH_FILTER_EN
module cmd_ext_trigger #(
  parameter int DELAY_WIDTH = 8,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                   CMD_CLK_IN,
  input  logic                   CMD_RST_N,
  input  logic                   TRIG_IN,
  input  logic                   CMD_EXT_START_ENABLE,
  input  logic                   CMD_READY,
  input  logic                   CONF_TRIG_INVERT,
  input  logic [DELAY_WIDTH-1:0] CONF_DELAY,
  input  logic [DELAY_WIDTH-1:0] CONF_DEADTIME,
  input  logic                   CNT_CLR,
  output logic                   CMD_EXT_START_FLAG,
  output logic                   TRIG_BUSY,
  output logic [CNT_WIDTH-1:0]   TRIG_ACCEPTED_CNT,
  output logic [CNT_WIDTH-1:0]   TRIG_VETOED_CNT
);

  typedef enum logic [1:0] {IDLE, DELAY, FIRE, DEAD} state_t;

  state_t                 state, state_next;
  logic [DELAY_WIDTH-1:0] cnt, cnt_next;
  logic [DELAY_WIDTH-1:0] dead_load;
  logic                   sync1, sync2;
  logic                   lvl, edge_lvl, lvl_prev, trig_edge;
  logic                   flag_d, busy_d, acc_inc, veto_inc;

  assign lvl = sync2 ^ CONF_TRIG_INVERT;

`ifdef CMD_TRIG_GLITCH_FILTER_EN
  // Filtered level only follows lvl once it has held for three samples.
  logic [1:0] hist;
  logic       filt_lvl;

  assign edge_lvl = (lvl == hist[0] && lvl == hist[1]) ? lvl : filt_lvl;

  always_ff @(posedge CMD_CLK_IN or negedge CMD_RST_N) begin
    if (!CMD_RST_N) begin
      hist     <= 2'b00;
      filt_lvl <= 1'b0;
    end else begin
      hist     <= {hist[0], lvl};
      filt_lvl <= edge_lvl;
    end
  end
`else
  assign edge_lvl = lvl;
`endif

  always_ff @(posedge CMD_CLK_IN or negedge CMD_RST_N) begin
    if (!CMD_RST_N) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      lvl_prev  <= 1'b0;
      trig_edge <= 1'b0;
    end else begin
      sync1     <= TRIG_IN;
      sync2     <= sync1;
      lvl_prev  <= edge_lvl;
      trig_edge <= edge_lvl & ~lvl_prev;
    end
  end

  // Dead time never shorter than the sequencer's ready-drop latency.
  assign dead_load = (CONF_DEADTIME < DELAY_WIDTH'(2)) ? DELAY_WIDTH'(2) : CONF_DEADTIME;

  always_ff @(posedge CMD_CLK_IN or negedge CMD_RST_N) begin
    if (!CMD_RST_N) begin
      state              <= IDLE;
      cnt                <= '0;
      CMD_EXT_START_FLAG <= 1'b0;
      TRIG_BUSY          <= 1'b0;
    end else begin
      state              <= state_next;
      cnt                <= cnt_next;
      CMD_EXT_START_FLAG <= flag_d;
      TRIG_BUSY          <= busy_d;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (trig_edge && CMD_EXT_START_ENABLE && CMD_READY) begin
          cnt_next   = CONF_DELAY;
          state_next = (CONF_DELAY == '0) ? FIRE : DELAY;
        end
      end
      DELAY: begin
        if (!CMD_EXT_START_ENABLE) begin
          state_next = IDLE;
        end else if (cnt == DELAY_WIDTH'(1)) begin
          state_next = FIRE;
        end else begin
          cnt_next = cnt - DELAY_WIDTH'(1);
        end
      end
      FIRE: begin
        cnt_next   = dead_load;
        state_next = DEAD;
      end
      DEAD: begin
        if (cnt == DELAY_WIDTH'(1)) begin
          state_next = IDLE;
        end else begin
          cnt_next = cnt - DELAY_WIDTH'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    flag_d   = (state_next == FIRE);
    busy_d   = (state_next != IDLE);
    acc_inc  = (state == FIRE);
    veto_inc = trig_edge &&
               ((state != IDLE) || (CMD_EXT_START_ENABLE && !CMD_READY));
  end

  // Clear beats a same-cycle increment; both counters stick at all-ones.
  always_ff @(posedge CMD_CLK_IN or negedge CMD_RST_N) begin
    if (!CMD_RST_N) begin
      TRIG_ACCEPTED_CNT <= '0;
      TRIG_VETOED_CNT   <= '0;
    end else if (CNT_CLR) begin
      TRIG_ACCEPTED_CNT <= '0;
      TRIG_VETOED_CNT   <= '0;
    end else begin
      if (acc_inc && TRIG_ACCEPTED_CNT != '1)
        TRIG_ACCEPTED_CNT <= TRIG_ACCEPTED_CNT + CNT_WIDTH'(1);
      if (veto_inc && TRIG_VETOED_CNT != '1)
        TRIG_VETOED_CNT <= TRIG_VETOED_CNT + CNT_WIDTH'(1);
    end
  end

endmodule

// File: doc/cmd_ext_trigger.md
Name: cmd_ext_trigger

Overview:
Upstream feeder of the command sequencer's external-start input. Converts an asynchronous external trigger (TLU / scintillator / lemo) into a single-cycle start flag in the command clock domain. Applies polarity select, programmable delay, dead time and a busy veto derived from the sequencer's ready signal. Keeps saturating counts of accepted and vetoed triggers for readout.

Parameters:
DELAY_WIDTH, 8, width of CONF_DELAY and CONF_DEADTIME
CNT_WIDTH, 16, width of the accepted/vetoed trigger counters

Ports:
CMD_CLK_IN  input  1  command clock; the sole clock of the block
CMD_RST_N  input  1  asynchronous, active-low reset
TRIG_IN  input  1  external trigger, asynchronous to CMD_CLK_IN
CMD_EXT_START_ENABLE  input  1  enable, already synchronised to CMD_CLK_IN
CMD_READY  input  1  sequencer idle indication, CMD_CLK_IN domain
CONF_TRIG_INVERT  input  1  0 = rising edge triggers, 1 = falling edge triggers
CONF_DELAY  input  DELAY_WIDTH  cycles between edge detection and flag
CONF_DEADTIME  input  DELAY_WIDTH  minimum cycles after a flag before re-arming
CNT_CLR  input  1  synchronous clear of both counters
CMD_EXT_START_FLAG  output  1  one-cycle start pulse to the sequencer
TRIG_BUSY  output  1  high whenever state is not IDLE
TRIG_ACCEPTED_CNT  output  CNT_WIDTH  triggers that produced a flag
TRIG_VETOED_CNT  output  CNT_WIDTH  triggers that were dropped

Behaviour:
- Reset (CMD_RST_N=0, asynchronous): state=IDLE; sync flops=0; all outputs=0.
- Input path: 2-flop synchroniser, XOR with CONF_TRIG_INVERT, then a registered edge detector producing trig_edge.
- Latency from a TRIG_IN edge (setup met) to trig_edge high: 3 cycles.
- FSM states: IDLE, DELAY, FIRE, DEAD.
- IDLE, trig_edge & CMD_EXT_START_ENABLE & CMD_READY: accept. Load delay counter with CONF_DELAY.
  - Go to DELAY if CONF_DELAY != 0; otherwise go directly to FIRE.
- IDLE, trig_edge & CMD_EXT_START_ENABLE & !CMD_READY: stay in IDLE, TRIG_VETOED_CNT+1.
- IDLE, trig_edge with enable low: ignored, not counted.
- DELAY: decrement each cycle; go to FIRE on the cycle the counter equals 1.
  - Total edge-to-flag cycles = CONF_DELAY+1 (1 when CONF_DELAY=0).
- FIRE: CMD_EXT_START_FLAG=1 for exactly this cycle (registered output), TRIG_ACCEPTED_CNT+1.
  - Load dead counter with max(CONF_DEADTIME, 2) and go to DEAD.
  - The floor of 2 covers the sequencer's ready-drop latency.
- DEAD: decrement; return to IDLE when the counter reaches 1. Re-arming in IDLE still requires CMD_READY.
- trig_edge while in DELAY, FIRE or DEAD: dropped, TRIG_VETOED_CNT+1.
- CMD_EXT_START_ENABLE falling while in DELAY: abort to IDLE, no flag, no count.
- CMD_EXT_START_ENABLE falling while in FIRE or DEAD: sequence completes normally.
- Counters: saturate at all-ones, no wrap.
  - CNT_CLR has priority over a same-cycle increment; both counters read 0 on the next cycle.
- CONF_* inputs are quasi-static. They are sampled only when the delay or dead counter is loaded.
- TRIG_BUSY = (state != IDLE), registered together with state.

Optional Feature:
CMD_TRIG_GLITCH_FILTER_EN
- Defined: the synchronised trigger level must hold the same value for 3 consecutive cycles before the edge detector sees it.
  - Pulses shorter than 3 cycles are rejected and not counted.
  - TRIG_IN-to-trig_edge latency becomes 5 cycles.
- Undefined: no filter; latency 3 cycles; any pulse of at least one clock period that is caught by the synchroniser is a trigger.

Test Plan:
1. Reset then idle: CMD_RST_N low for 5 cycles, TRIG_IN=0 -> all outputs 0, TRIG_BUSY=0.
2. Basic accept: enable=1, READY=1, CONF_DELAY=0, TRIG_IN rising -> exactly one flag pulse 4 cycles after the edge; ACCEPTED_CNT=1.
3. Delay and dead time: CONF_DELAY=10, CONF_DEADTIME=20, two edges 15 cycles apart -> one flag 14 cycles after the first edge; second edge counted VETOED=1.
4. Busy veto: READY=0, 3 edges -> no flag, VETOED_CNT=3. Then READY=1 and one falling edge with INVERT=1 -> one flag; ACCEPTED_CNT=1.
5. Abort and clear: CONF_DELAY=50, drop enable 10 cycles after the edge -> no flag, counters unchanged. CNT_CLR asserted in the same cycle as a vetoed edge -> both counters 0.
6. Saturation and filter: CNT_WIDTH=4, 20 accepted triggers -> ACCEPTED_CNT=15. With CMD_TRIG_GLITCH_FILTER_EN defined, a 2-cycle pulse -> no flag and no count; a 4-cycle pulse -> flag 6 cycles after its rising edge (CONF_DELAY=0).
